// File: rtl/vdata_serializer.sv
// vdata_serializer
// Accepts parallel video tuples {sync, R, G, B} through a valid/ready handshake
// and buffers them in a 2-entry FIFO. Each tuple is then re-serialised onto a
// COLOR_W-bit bus as four symbols (sync, R, G, B), with nDSYNC_o low on the sync
// symbol. Once started, the symbol stream never stalls: if the FIFO is empty
// when a new tuple is due, the previous tuple is replayed and underrun_o pulses.
//
// Optional feature macro: VDATA_SER_UNDERRUN_CNT_EN
//   When defined, adds underrun_cnt_o, a saturating 8-bit count of underruns.
module vdata_serializer #(
    parameter int COLOR_W = 7,
    parameter int SYNC_W  = 4
) (
    input  logic                          VCLK,
    input  logic                          RST,
    input  logic                          vdata_valid_i,
    input  logic [SYNC_W+3*COLOR_W-1:0]   vdata_i,
    output logic                          vdata_ready_o,
    output logic                          nDSYNC_o,
    output logic [COLOR_W-1:0]            D_o,
    output logic                          underrun_o
`ifdef VDATA_SER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                    underrun_cnt_o
`endif
);

    localparam int TUP_W = SYNC_W + 3 * COLOR_W;

    // Tuple field positions: [sync | R | G | B], B in the low bits.
    localparam int B_LO = 0;
    localparam int G_LO = COLOR_W;
    localparam int R_LO = 2 * COLOR_W;
    localparam int S_LO = 3 * COLOR_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SY   = 3'd1,
        ST_RE   = 3'd2,
        ST_GR   = 3'd3,
        ST_BL   = 3'd4
    } state_t;

    // Zero-extend the sync bits onto the symbol bus.
    function automatic logic [COLOR_W-1:0] sync_symbol(input logic [SYNC_W-1:0] s);
        logic [COLOR_W-1:0] v;
        v = '0;
        v[SYNC_W-1:0] = s;
        return v;
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // FIFO storage and control
    logic [TUP_W-1:0] r_fifo [0:1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             r_ready;

    // Serialiser state
    state_t           r_state;
    logic [TUP_W-1:0] r_hold;
    logic             r_replay;

    // Registered outputs
    logic             r_ndsync;
    logic [COLOR_W-1:0] r_d;
    logic             r_underrun;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_next;

    assign w_push = vdata_valid_i && r_ready;
    // A new tuple is taken when starting up from IDLE or at the end of a tuple;
    // both only when something is queued.
    assign w_pop  = ((r_state == ST_IDLE) || (r_state == ST_BL)) && (r_cnt != 2'd0);

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_cnt + 2'd1;
            2'b01:   w_cnt_next = r_cnt - 2'd1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    // FIFO data array: written on push only, contents need no reset.
    always_ff @(posedge VCLK) begin
        if (w_push) begin
            r_fifo[r_wptr] <= vdata_i;
        end
    end

    // FIFO pointers, occupancy and registered ready; reset flushes the FIFO.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt   <= w_cnt_next;
            r_ready <= (w_cnt_next < 2'd2);
        end
    end

    // Symbol sequencer: loads the hold register and flags replayed tuples.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_hold   <= '0;
            r_replay <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_hold   <= r_fifo[r_rptr];
                        r_replay <= 1'b0;
                        r_state  <= ST_SY;
                    end
                end
                ST_SY: r_state <= ST_RE;
                ST_RE: r_state <= ST_GR;
                ST_GR: r_state <= ST_BL;
                ST_BL: begin
                    // Never stall the stream: with nothing queued, keep the
                    // hold register and send it again.
                    if (w_pop) begin
                        r_hold   <= r_fifo[r_rptr];
                        r_replay <= 1'b0;
                    end else begin
                        r_replay <= 1'b1;
                    end
                    r_state <= ST_SY;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output symbol register: reflects the state held during the previous cycle.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_ndsync   <= 1'b1;
            r_d        <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_ndsync   <= 1'b1;
            r_d        <= '0;
            r_underrun <= 1'b0;
            case (r_state)
                ST_SY: begin
                    r_ndsync   <= 1'b0;
                    r_d        <= sync_symbol(r_hold[S_LO +: SYNC_W]);
                    r_underrun <= r_replay;
                end
                ST_RE:   r_d <= r_hold[R_LO +: COLOR_W];
                ST_GR:   r_d <= r_hold[G_LO +: COLOR_W];
                ST_BL:   r_d <= r_hold[B_LO +: COLOR_W];
                default: r_d <= '0;
            endcase
        end
    end

`ifdef VDATA_SER_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    // Underrun counter: steps on the same edge that raises underrun_o.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_underrun_cnt <= 8'd0;
        end else if ((r_state == ST_SY) && r_replay) begin
            r_underrun_cnt <= sat_inc8(r_underrun_cnt);
        end
    end

    assign underrun_cnt_o = r_underrun_cnt;
`endif

    assign vdata_ready_o = r_ready;
    assign nDSYNC_o      = r_ndsync;
    assign D_o           = r_d;
    assign underrun_o    = r_underrun;

endmodule
